// File: rtl/pipeline_debug_pkg.sv
// Shared command codes, FSM state encoding and frame sizing for the pipeline debug unit.
package pipeline_debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        CAPTURE,
        SEND
    } state_t;

    // Frame is the debug words followed by one word of cycle count.
    function automatic int unsigned snap_bytes(input int unsigned num_words);
        return 4 * (num_words + 1);
    endfunction

endpackage

// File: rtl/pipeline_debug_unit_if.sv
// UART-side byte links of the debug unit: command bytes in, snapshot bytes out.
interface pipeline_debug_unit_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/pipeline_debug_unit_serializer.sv
// Shadow register plus byte pointer; streams the latched frame LSB-first over valid/ready.
module debug_byte_serializer #(
    parameter int unsigned NUM_BYTES = 36
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic                   done
);

    localparam int unsigned IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    logic [8*NUM_BYTES-1:0] shadow;
    logic [IDX_W-1:0]       byte_idx;
    logic [IDX_W-1:0]       next_idx;
    logic                   accept;

    assign accept   = tx_valid && tx_ready;
    assign done     = accept && (byte_idx == LAST_IDX);
    assign next_idx = byte_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (load) begin
                shadow   <= data;
                byte_idx <= '0;
            end
            // Byte 0 comes straight from the incoming data so it is valid on the load edge.
            if (start) begin
                tx_valid <= 1'b1;
                tx_data  <= load ? data[7:0] : shadow[7:0];
            end else if (accept) begin
                if (done) begin
                    tx_valid <= 1'b0;
                end else begin
                    byte_idx <= next_idx;
                    tx_data  <= shadow[8*next_idx +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_debug_unit.sv
// Host-side debug controller: run/halt/step gating of the pipeline clock enable and snapshot dump.
module pipeline_debug_unit
    import pipeline_debug_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_debug_unit_if.master  host,
    input  logic [32*NUM_WORDS-1:0] snap_words,
    output logic                   pipe_enable,
    output logic                   busy,
    output logic [31:0]            cycle_count
);

    localparam int unsigned NUM_BYTES = snap_bytes(NUM_WORDS);

    state_t state, state_n;
    logic   run_mode, run_mode_n;
    logic   load;
    logic   done;

    always_comb begin
        state_n    = state;
        run_mode_n = run_mode;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (host.rx_valid) begin
                    if (!run_mode) begin
                        case (host.rx_data)
                            CMD_RUN:  run_mode_n = 1'b1;
                            CMD_STEP: state_n    = STEP;
                            CMD_DUMP: state_n    = CAPTURE;
                            default:  ;
                        endcase
                    end else if (host.rx_data == CMD_HALT) begin
                        run_mode_n = 1'b0;
                        state_n    = CAPTURE;
                    end
                end
            end
            STEP:    state_n = CAPTURE;
            CAPTURE: begin
                load    = 1'b1;
                state_n = SEND;
            end
            SEND:    if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            run_mode    <= 1'b0;
            pipe_enable <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            run_mode    <= run_mode_n;
            // Enable is derived from next state so it is never high during CAPTURE or SEND.
            pipe_enable <= (state_n == STEP) || run_mode_n;
            busy        <= (state_n != IDLE);
            if (pipe_enable) cycle_count <= cycle_count + 32'd1;
        end
    end

    debug_byte_serializer #(
        .NUM_BYTES (NUM_BYTES)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .start    (load),
        .data     ({cycle_count, snap_words}),
        .tx_ready (host.tx_ready),
        .tx_data  (host.tx_data),
        .tx_valid (host.tx_valid),
        .done     (done)
    );

endmodule
